// File: rtl/cmp_serial_cascade.sv
// Serial magnitude comparator: consumes two operands 2 bits per beat, MSB slice first,
// and presents equal/gt/lt for each completed word behind a valid/ready handshake.
module cmp_serial_cascade #(
    parameter int unsigned SLICES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_first,
    input  logic [1:0] a_slice,
    input  logic [1:0] b_slice,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       equal,
    output logic       gt,
    output logic       lt,
    output logic       seq_err,
    output logic [7:0] word_cnt
);

    localparam int unsigned CW = $clog2(SLICES + 1);
    localparam logic [CW-1:0] LAST = CW'(SLICES);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          dgt;
    logic          dlt;

    logic          accept;
    logic          slice_gt;
    logic          slice_lt;
    logic          nxt_gt;
    logic          nxt_lt;
    logic [CW-1:0] cnt_inc;

    assign accept   = in_valid & in_ready;
    assign slice_gt = (a_slice > b_slice);
    assign slice_lt = (a_slice < b_slice);
    // The first differing slice (most significant) decides; later slices cannot override it.
    assign nxt_gt   = (dgt | dlt) ? dgt : slice_gt;
    assign nxt_lt   = (dgt | dlt) ? dlt : slice_lt;
    assign cnt_inc  = cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dgt       <= 1'b0;
            dlt       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            equal     <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            seq_err   <= 1'b0;
            word_cnt  <= '0;
        end else begin
            seq_err <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (in_first) begin
                            state <= ACCUM;
                            cnt   <= CW'(1);
                            dgt   <= slice_gt;
                            dlt   <= slice_lt;
                        end else begin
                            seq_err <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (in_first) begin
                            // Framing restart: the partial word is abandoned.
                            cnt     <= CW'(1);
                            dgt     <= slice_gt;
                            dlt     <= slice_lt;
                            seq_err <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                            dgt <= nxt_gt;
                            dlt <= nxt_lt;
                            if (cnt_inc == LAST) begin
                                state     <= HOLD;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                                gt        <= nxt_gt;
                                lt        <= nxt_lt;
                                equal     <= ~(nxt_gt | nxt_lt);
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        dgt       <= 1'b0;
                        dlt       <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        equal     <= 1'b0;
                        gt        <= 1'b0;
                        lt        <= 1'b0;
                        word_cnt  <= word_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
